// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution layer sequencer.
//   state_t      - sequencer FSM state encoding
//   kwords()     - weight words per layer: 9*CHANEL*FILTER kernel taps + FILTER biases
//   addr_width() - address width for a memory of the given depth (minimum 1 bit)
//   KWORDS       - weight word count for the default 8-channel, 16-filter layer
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_K = 3'd1,
      WAIT_K = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_t;

   function automatic int unsigned kwords(input int unsigned chanel, input int unsigned filter);
      return 9 * chanel * filter + filter;
   endfunction

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned KWORDS = kwords(8, 16);

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: cycle counter that flags when a wait state has lasted TIMEOUT cycles.
// Only instantiated when CONV_SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk, resetn - clock and asynchronous active-low reset
//   clear       - restart the count from zero (takes priority over enable)
//   enable      - count this cycle
//   expire      - high in the TIMEOUT-th consecutive enabled cycle
module seq_watchdog
   import conv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CW = addr_width(TIMEOUT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expire = enable && !clear && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: drives one convolution layer pass. On the first pass after reset it
// streams all kernel words from weight memory into the datapath, then streams every pixel
// address; later passes skip the kernel load because the datapath keeps its kernel until reset.
// Optional watchdog on WAIT_K/DRAIN: define CONV_SEQ_TIMEOUT_EN.
// Ports:
//   clk, resetn                  - clock, asynchronous active-low reset
//   start                        - begin a pass (ignored unless idle)
//   wt_rd_en, wt_addr, wt_data   - weight memory read (data one cycle after enable)
//   px_rd_en, px_addr, px_stall  - pixel memory read, stalled while px_stall is high
//   load_kernel, kernel          - kernel word strobe/data to the datapath
//   data_valid_in                - pixel data strobe to the datapath
//   load_kernel_done, done_img   - datapath status
//   busy, done, err              - sequencer status (done/err are 1-cycle pulses)
module conv_layer_sequencer
   import conv_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned HEIGHT  = 8,
   parameter int unsigned CHANEL  = 8,
   parameter int unsigned FILTER  = 16,
   parameter int unsigned TIMEOUT = 1024,
   localparam int unsigned KA     = addr_width(kwords(CHANEL, FILTER)),
   localparam int unsigned PA     = addr_width(WIDTH * HEIGHT)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   output logic          wt_rd_en,
   output logic [KA-1:0] wt_addr,
   input  logic [31:0]   wt_data,
   output logic          px_rd_en,
   output logic [PA-1:0] px_addr,
   input  logic          px_stall,
   output logic          load_kernel,
   output logic [31:0]   kernel,
   output logic          data_valid_in,
   input  logic          load_kernel_done,
   input  logic          done_img,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned NWORDS = kwords(CHANEL, FILTER);
   localparam int unsigned NPIX   = WIDTH * HEIGHT;

   state_t        r_state, w_state_next;
   logic [KA-1:0] r_wt_addr;
   logic [PA-1:0] r_px_addr;
   logic          r_kernel_loaded;
   logic          r_img_done;
   logic          r_load_kernel;
   logic          r_data_valid;
   logic          r_err;
   logic          w_wt_last;
   logic          w_px_rd;
   logic          w_px_last;
   logic          w_img_done;
   logic          w_expire;

   assign w_wt_last  = (r_wt_addr == KA'(NWORDS - 1));
   assign w_px_rd    = (r_state == STREAM) && !px_stall;
   assign w_px_last  = (r_px_addr == PA'(NPIX - 1));
   // done_img may arrive before the last pixel read; the latch keeps it for DRAIN.
   assign w_img_done = done_img || r_img_done;

`ifdef CONV_SEQ_TIMEOUT_EN
   logic w_wd_en;

   assign w_wd_en = ((r_state == WAIT_K) && !load_kernel_done) ||
                    ((r_state == DRAIN) && !w_img_done);

   seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_seq_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clear  (!w_wd_en),
      .enable (w_wd_en),
      .expire (w_expire)
   );
`else
   // No watchdog built: waits are unbounded and TIMEOUT has no effect.
   assign w_expire = 1'b0 & (TIMEOUT == 0);
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_next = r_kernel_loaded ? STREAM : LOAD_K;
         LOAD_K:  if (w_wt_last) w_state_next = WAIT_K;
         WAIT_K: begin
            if (load_kernel_done) w_state_next = STREAM;
            else if (w_expire)    w_state_next = IDLE;
         end
         STREAM:  if (w_px_rd && w_px_last) w_state_next = DRAIN;
         DRAIN: begin
            if (w_img_done)    w_state_next = DONE;
            else if (w_expire) w_state_next = IDLE;
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Addresses, flags and the one-cycle-delayed datapath strobes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wt_addr       <= '0;
         r_px_addr       <= '0;
         r_kernel_loaded <= 1'b0;
         r_img_done      <= 1'b0;
         r_load_kernel   <= 1'b0;
         r_data_valid    <= 1'b0;
         r_err           <= 1'b0;
      end else begin
         r_load_kernel <= (r_state == LOAD_K);
         r_data_valid  <= w_px_rd;
         r_err         <= w_expire;

         if (r_state == LOAD_K) begin
            r_wt_addr <= w_wt_last ? '0 : r_wt_addr + 1'b1;
         end

         // Sticky until reset: the datapath kernel counter cannot be rewound.
         if ((r_state == WAIT_K) && load_kernel_done) begin
            r_kernel_loaded <= 1'b1;
         end

         if (w_px_rd && !w_px_last) begin
            r_px_addr <= r_px_addr + 1'b1;
         end else if ((r_state == DONE) || w_expire) begin
            r_px_addr <= '0;
         end

         if ((r_state == STREAM) && done_img) begin
            r_img_done <= 1'b1;
         end else if ((r_state == DONE) || (r_state == IDLE)) begin
            r_img_done <= 1'b0;
         end
      end
   end

   // Outputs
   always_comb begin
      busy          = (r_state != IDLE);
      done          = (r_state == DONE);
      err           = r_err;
      wt_rd_en      = (r_state == LOAD_K);
      wt_addr       = r_wt_addr;
      px_rd_en      = w_px_rd;
      px_addr       = r_px_addr;
      load_kernel   = r_load_kernel;
      kernel        = r_load_kernel ? wt_data : 32'h0;
      data_valid_in = r_data_valid;
   end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
module tb_conv_layer_sequencer;

   localparam int KW   = 9 * 8 * 16 + 16;  // 1168 weight words
   localparam int NPIX = 8 * 8;
   localparam int TO   = 16;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        wt_rd_en;
   logic [10:0] wt_addr;
   logic [31:0] wt_data;
   logic        px_rd_en;
   logic [5:0]  px_addr;
   logic        px_stall;
   logic        load_kernel;
   logic [31:0] kernel;
   logic        data_valid_in;
   logic        load_kernel_done;
   logic        done_img;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] wmem [KW];
   int lk_cnt, wa_cnt, dv_cnt, rd_cnt, exp_px, done_cnt;

   conv_layer_sequencer #(
      .WIDTH   (8),
      .HEIGHT  (8),
      .CHANEL  (8),
      .FILTER  (16),
      .TIMEOUT (TO)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .start            (start),
      .wt_rd_en         (wt_rd_en),
      .wt_addr          (wt_addr),
      .wt_data          (wt_data),
      .px_rd_en         (px_rd_en),
      .px_addr          (px_addr),
      .px_stall         (px_stall),
      .load_kernel      (load_kernel),
      .kernel           (kernel),
      .data_valid_in    (data_valid_in),
      .load_kernel_done (load_kernel_done),
      .done_img         (done_img),
      .busy             (busy),
      .done             (done),
      .err              (err)
   );

   always #5 clk = ~clk;

   // Weight memory: one-cycle read latency, garbage on the bus when not read.
   always @(posedge clk) begin
      if (wt_rd_en) wt_data <= wmem[wt_addr];
      else          wt_data <= $urandom;
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, "_busy"}, busy, 1'b0);
      check1({tag, "_done"}, done, 1'b0);
      check1({tag, "_err"}, err, 1'b0);
      check1({tag, "_wt_rd_en"}, wt_rd_en, 1'b0);
      checkv({tag, "_wt_addr"}, 64'(wt_addr), 64'd0);
      check1({tag, "_px_rd_en"}, px_rd_en, 1'b0);
      checkv({tag, "_px_addr"}, 64'(px_addr), 64'd0);
      check1({tag, "_load_kernel"}, load_kernel, 1'b0);
      checkv({tag, "_kernel"}, 64'(kernel), 64'd0);
      check1({tag, "_data_valid_in"}, data_valid_in, 1'b0);
   endtask

   // Per-cycle monitor against the reference sequences
   always @(negedge clk) begin
      if (resetn) begin
         if (wt_rd_en) begin
            checkv("wt_addr_seq", 64'(wt_addr), 64'(wa_cnt));
            wa_cnt++;
         end
         if (load_kernel) begin
            checkv("kernel_word", 64'(kernel), (lk_cnt < KW) ? 64'(wmem[lk_cnt]) : 64'hdead);
            lk_cnt++;
         end else begin
            checkv("kernel_idle", 64'(kernel), 64'd0);
         end
         check1("lk_dv_exclusive", load_kernel & data_valid_in, 1'b0);
         if (px_rd_en) begin
            checkv("px_addr_seq", 64'(px_addr), 64'(exp_px));
            exp_px++;
            rd_cnt++;
         end
         if (data_valid_in) dv_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic clear_counts();
      lk_cnt = 0; wa_cnt = 0; dv_cnt = 0; rd_cnt = 0; exp_px = 0; done_cnt = 0;
   endtask

   // stall_mode: 0 none, 1 stall in STREAM cycles 10-14, 2 random
   task automatic run_pass(input bit exp_load, input int stall_mode, input bit early_img,
                           input bit start_in_stream, input bit withhold);
      int budget;
      int scyc;
      clear_counts();
      px_stall = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (exp_load) begin
         check1("enter_load_k", wt_rd_en, 1'b1);
         budget = 0;
         while (lk_cnt < KW && budget < KW + 20) begin
            tick();
            budget++;
         end
         checkv("load_kernel_count", 64'(lk_cnt), 64'(KW));
         check1("wait_k_no_load", load_kernel, 1'b0);
         check1("wait_k_busy", busy, 1'b1);
         repeat ($urandom_range(0, 4)) tick();
         check1("wait_k_no_read", px_rd_en, 1'b0);
         load_kernel_done = 1'b1;
         tick();
         load_kernel_done = 1'b0;
         check1("enter_stream", px_rd_en, 1'b1);
      end else begin
         check1("stream_direct", px_rd_en, 1'b1);
         check1("stream_direct_no_wt", wt_rd_en, 1'b0);
      end
      scyc = 0;
      budget = 0;
      while (rd_cnt < NPIX && budget < 4 * NPIX) begin
         case (stall_mode)
            1:       px_stall = (scyc >= 10) && (scyc <= 14);
            2:       px_stall = ($urandom_range(0, 3) == 0);
            default: px_stall = 1'b0;
         endcase
         done_img = early_img && (scyc == 20);
         start = start_in_stream && (scyc == 5);
         tick();
         scyc++;
         budget++;
      end
      px_stall = 1'b0;
      done_img = 1'b0;
      start = 1'b0;
      checkv("reads_total", 64'(rd_cnt), 64'(NPIX));
      if (withhold) begin
`ifdef CONV_SEQ_TIMEOUT_EN
         repeat (TO - 1) tick();
         check1("wd_err_early", err, 1'b0);
         check1("wd_busy_early", busy, 1'b1);
         tick();
         check1("wd_err_pulse", err, 1'b1);
         check1("wd_idle", busy, 1'b0);
         tick();
         check1("wd_err_end", err, 1'b0);
         checkv("wd_px_addr_clr", 64'(px_addr), 64'd0);
`else
         repeat (40) tick();
         check1("no_wd_err", err, 1'b0);
         check1("no_wd_busy", busy, 1'b1);
         done_img = 1'b1;
         tick();
         done_img = 1'b0;
         check1("late_done", done, 1'b1);
         tick();
`endif
         return;
      end
      if (early_img) begin
         tick();
         check1("done_latched", done, 1'b1);
      end else begin
         repeat ($urandom_range(0, 5)) tick();
         check1("drain_wait", done, 1'b0);
         done_img = 1'b1;
         tick();
         done_img = 1'b0;
         check1("done_pulse", done, 1'b1);
      end
      tick();
      check1("done_one_cycle", done, 1'b0);
      check1("idle_after_done", busy, 1'b0);
      checkv("px_addr_cleared", 64'(px_addr), 64'd0);
      checkv("data_valid_total", 64'(dv_cnt), 64'(NPIX));
      checkv("load_kernel_total", 64'(lk_cnt), exp_load ? 64'(KW) : 64'd0);
      repeat (3) tick();
      checkv("done_pulse_count", 64'(done_cnt), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed simulation still running expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int budget;
      for (int i = 0; i < KW; i++) wmem[i] = $urandom;
      clear_counts();
      resetn = 1'b0;
      start = 1'b0;
      px_stall = 1'b0;
      load_kernel_done = 1'b0;
      done_img = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      resetn = 1'b1;
      tick();

      // First pass loads the kernel
      run_pass(1'b1, 0, 1'b0, 1'b0, 1'b0);
      // No reload; stall window; start during STREAM ignored
      run_pass(1'b0, 1, 1'b0, 1'b1, 1'b0);
      // Random stalls, done_img arriving during STREAM
      run_pass(1'b0, 2, 1'b1, 1'b0, 1'b0);
      // done_img withheld in DRAIN
      run_pass(1'b0, 2, 1'b0, 1'b0, 1'b1);
      // Kernel stays loaded after a watchdog abort or a late done
      run_pass(1'b0, 0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a kernel load (kernel_loaded is cleared)
      for (int i = 0; i < KW; i++) wmem[i] = $urandom;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      clear_counts();
      start = 1'b1;
      tick();
      start = 1'b0;
      budget = 0;
      while (lk_cnt < 500 && budget < 600) begin
         tick();
         budget++;
      end
      checkv("mid_load_count", 64'(lk_cnt), 64'd500);
      resetn = 1'b0;
      #1;
      check_all_zero("async_reset");
      tick();
      check_all_zero("held_reset");
      resetn = 1'b1;
      run_pass(1'b1, 2, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
